wb_commit_checker: RTL and testbench

- Synthesizable writeback-stage observer, directly downstream of the pipelined ARM core's writeback stage.
- Consumes the writeback port (RegWriteW, WA3W, ResultW) and maintains a shadow copy of R0–R14.
- Streams every commit through a small trace FIFO with a valid/ready drain.
- On program halt or timeout, compares the shadow registers against preloaded expected values and reports pass/fail in hardware.
- Replaces ad-hoc end-of-sim hierarchical register peeks.

---
 rtl/wb_commit_checker.sv | 240 ++++++++++++++++++++++++
 tb/tb_wb_commit_checker.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_checker.sv
// ---------------------------------------------------------------------------
// wb_commit_checker
//
// Observer that sits directly behind the pipelined ARM core's writeback stage.
// It keeps a shadow copy of R0..R14 built from the writeback port and streams
// every commit through a small trace FIFO with a valid/ready drain. When the
// program halts, or the run times out, it compares the shadow registers
// against preloaded expected values and reports pass/fail in hardware.
//
// Ports:
//   clk            core clock
//   reset          asynchronous reset, active low
//   RegWriteW      writeback enable from the core
//   WA3W           writeback destination register
//   ResultW        writeback data
//   run_en         start-observation pulse (IDLE only)
//   halt           program-complete strobe (RUN only)
//   exp_we         expected-value write strobe (IDLE only)
//   exp_idx        expected-value register index
//   exp_val        expected value
//   trace_valid    trace FIFO head valid
//   trace_ready    consumer accepts the head entry
//   trace_idx      head register index
//   trace_data     head result value
//   trace_cycle    head commit cycle (RUN-relative)
//   commit_count   shadowed commits accepted in RUN (saturating)
//   overflow       sticky: a commit was dropped because the FIFO was full
//   timed_out      sticky: the RUN cycle limit was reached
//   done           check complete, held until reset
//   pass           result, meaningful when done=1
//   fail_idx       first mismatching register index, 4'hF if none
// ---------------------------------------------------------------------------
module wb_commit_checker #(
    parameter int DATA_W     = 32,
    parameter int NREGS      = 15,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 2500,
    parameter int CYC_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic [3:0]        WA3W,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              run_en,
    input  logic              halt,
    input  logic              exp_we,
    input  logic [3:0]        exp_idx,
    input  logic [DATA_W-1:0] exp_val,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [3:0]        trace_idx,
    output logic [DATA_W-1:0] trace_data,
    output logic [CYC_W-1:0]  trace_cycle,
    output logic [CYC_W-1:0]  commit_count,
    output logic              overflow,
    output logic              timed_out,
    output logic              done,
    output logic              pass,
    output logic [3:0]        fail_idx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [4:0]       NREGS_L      = 5'(NREGS);
    localparam logic [3:0]       LAST_IDX     = 4'(NREGS - 1);
    localparam logic [3:0]       NO_FAIL      = 4'hF;
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL_L  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } stateT;

    stateT state, nextState;

    logic [DATA_W-1:0] shadowRegs   [NREGS];
    logic [DATA_W-1:0] expectedRegs [NREGS];
    logic [NREGS-1:0]  checkMask;

    logic [CYC_W-1:0] cycleCnt;
    logic [CYC_W-1:0] commitCnt;
    logic [3:0]       checkIdx;
    logic [3:0]       failIdx;
    logic             overflowFlag;
    logic             timedOutFlag;

    logic [3:0]        fifoIdx  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifoData [FIFO_DEPTH];
    logic [CYC_W-1:0]  fifoCyc  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  fifoCount;

    logic wbInRange;
    logic expInRange;
    logic isCommit;
    logic expWrite;
    logic timeoutHit;
    logic fifoFull;
    logic doPop;
    logic doPush;

    // PC writes (index 15) never count as commits; exp_idx is filtered the same way.
    assign wbInRange  = {1'b0, WA3W} < NREGS_L;
    assign expInRange = {1'b0, exp_idx} < NREGS_L;
    assign isCommit   = (state == RUN) && RegWriteW && wbInRange;
    assign expWrite   = (state == IDLE) && exp_we && expInRange;
    assign timeoutHit = (state == RUN) && (cycleCnt == TIMEOUT_LAST);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign fifoFull    = (fifoCount == FIFO_FULL_L);
    assign trace_valid = (fifoCount != '0);
    assign doPop       = trace_valid && trace_ready;
    assign doPush      = isCommit && (!fifoFull || doPop);

    // Head fields are forced to zero while empty so stale storage never leaks out.
    assign trace_idx    = trace_valid ? fifoIdx[rdPtr]  : '0;
    assign trace_data   = trace_valid ? fifoData[rdPtr] : '0;
    assign trace_cycle  = trace_valid ? fifoCyc[rdPtr]  : '0;
    assign commit_count = commitCnt;
    assign overflow     = overflowFlag;
    assign timed_out    = timedOutFlag;
    assign done         = (state == DONE);
    assign pass         = (state == DONE) && (failIdx == NO_FAIL) && !timedOutFlag;
    assign fail_idx     = failIdx;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: CHECK walks every register index exactly once.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (run_en) nextState = RUN;
            RUN:     if (halt || timeoutHit) nextState = CHECK;
            CHECK:   if (checkIdx == LAST_IDX) nextState = DONE;
            DONE:    nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    // Cycle and commit counters, both saturating; the cycle count restarts on entry to RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycleCnt     <= '0;
            commitCnt    <= '0;
            timedOutFlag <= 1'b0;
        end else begin
            if (state == IDLE && run_en) begin
                cycleCnt <= '0;
            end else if (state == RUN && cycleCnt != '1) begin
                cycleCnt <= cycleCnt + CYC_W'(1);
            end
            if (isCommit && commitCnt != '1) begin
                commitCnt <= commitCnt + CYC_W'(1);
            end
            if (timeoutHit) begin
                timedOutFlag <= 1'b1;
            end
        end
    end

    // Shadow registers follow commits; expected values and mask load in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                shadowRegs[i]   <= '0;
                expectedRegs[i] <= '0;
            end
            checkMask <= '0;
        end else begin
            if (isCommit) begin
                shadowRegs[WA3W] <= ResultW;
            end
            if (expWrite) begin
                expectedRegs[exp_idx] <= exp_val;
                checkMask[exp_idx]    <= 1'b1;
            end
        end
    end

    // Serial compare, one index per CHECK cycle; only the first mismatch is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checkIdx <= '0;
            failIdx  <= NO_FAIL;
        end else if (state == CHECK) begin
            checkIdx <= checkIdx + 4'd1;
            if (checkMask[checkIdx] && (shadowRegs[checkIdx] != expectedRegs[checkIdx])
                && (failIdx == NO_FAIL)) begin
                failIdx <= checkIdx;
            end
        end
    end

    // Trace FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            fifoCount    <= '0;
            overflowFlag <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                fifoCount <= fifoCount + CNT_W'(1);
            end else if (doPop && !doPush) begin
                fifoCount <= fifoCount - CNT_W'(1);
            end
            if (isCommit && !doPush) begin
                overflowFlag <= 1'b1;
            end
        end
    end

    // Trace storage needs no reset: entries are only visible behind trace_valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoIdx[wrPtr]  <= WA3W;
            fifoData[wrPtr] <= ResultW;
            fifoCyc[wrPtr]  <= cycleCnt;
        end
    end

endmodule

// File: tb/tb_wb_commit_checker.sv
// ---------------------------------------------------------------------------
// tb_wb_commit_checker
//
// Directed scoreboard bench for wb_commit_checker. Stimulus tasks push the
// expected trace entries into a queue; an independent monitor pops and
// compares whenever the DUT hands over a trace entry. Status outputs are
// checked against hand-computed values after each scenario.
// ---------------------------------------------------------------------------
module tb_wb_commit_checker;

    localparam int DATA_W     = 32;
    localparam int NREGS      = 15;
    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 2500;
    localparam int CYC_W      = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              RegWriteW;
    logic [3:0]        WA3W;
    logic [DATA_W-1:0] ResultW;
    logic              run_en;
    logic              halt;
    logic              exp_we;
    logic [3:0]        exp_idx;
    logic [DATA_W-1:0] exp_val;
    logic              trace_valid;
    logic              trace_ready;
    logic [3:0]        trace_idx;
    logic [DATA_W-1:0] trace_data;
    logic [CYC_W-1:0]  trace_cycle;
    logic [CYC_W-1:0]  commit_count;
    logic              overflow;
    logic              timed_out;
    logic              done;
    logic              pass;
    logic [3:0]        fail_idx;

    typedef struct packed {
        logic [3:0]        idx;
        logic [DATA_W-1:0] data;
        logic [CYC_W-1:0]  cyc;
    } traceT;

    traceT expQ[$];
    int    checks   = 0;
    int    failures = 0;
    int    popCount = 0;
    int    runCycle = 0;

    always #5 clk = ~clk;

    wb_commit_checker #(
        .DATA_W     (DATA_W),
        .NREGS      (NREGS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT),
        .CYC_W      (CYC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RegWriteW    (RegWriteW),
        .WA3W         (WA3W),
        .ResultW      (ResultW),
        .run_en       (run_en),
        .halt         (halt),
        .exp_we       (exp_we),
        .exp_idx      (exp_idx),
        .exp_val      (exp_val),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_idx    (trace_idx),
        .trace_data   (trace_data),
        .trace_cycle  (trace_cycle),
        .commit_count (commit_count),
        .overflow     (overflow),
        .timed_out    (timed_out),
        .done         (done),
        .pass         (pass),
        .fail_idx     (fail_idx)
    );

    // Single comparison point: every check steps the counters printed in the summary.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: samples mid-cycle, when the handshake that the next edge acts on is stable.
    initial begin
        traceT e;
        forever begin
            @(negedge clk);
            if (reset && trace_valid && trace_ready) begin
                popCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedPop: got idx=%0d data=0x%0h cycle=%0d, required no entry",
                             trace_idx, trace_data, trace_cycle);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("traceIdx",   64'(trace_idx),   64'(e.idx));
                    checkOutput("traceData",  64'(trace_data),  64'(e.data));
                    checkOutput("traceCycle", 64'(trace_cycle), 64'(e.cyc));
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
        runCycle++;
    endtask

    task automatic applyReset();
        reset       = 1'b0;
        RegWriteW   = 1'b0;
        WA3W        = '0;
        ResultW     = '0;
        run_en      = 1'b0;
        halt        = 1'b0;
        exp_we      = 1'b0;
        exp_idx     = '0;
        exp_val     = '0;
        trace_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expQ.delete();
        reset = 1'b1;
    endtask

    task automatic loadExpected(input logic [3:0] idx, input logic [DATA_W-1:0] val);
        exp_we  = 1'b1;
        exp_idx = idx;
        exp_val = val;
        stepCycle();
        exp_we  = 1'b0;
    endtask

    task automatic runStart();
        run_en = 1'b1;
        @(posedge clk);
        #1;
        run_en   = 1'b0;
        runCycle = 0;
    endtask

    // One writeback cycle; keepTrace says whether the entry should reach the consumer.
    task automatic applyStimulus(input logic we, input logic [3:0] idx,
                                 input logic [DATA_W-1:0] data, input logic keepTrace);
        traceT e;
        RegWriteW = we;
        WA3W      = idx;
        ResultW   = data;
        if (keepTrace) begin
            e.idx  = idx;
            e.data = data;
            e.cyc  = CYC_W'(runCycle);
            expQ.push_back(e);
        end
        stepCycle();
        RegWriteW = 1'b0;
    endtask

    // Called right after the edge that entered CHECK: 15 CHECK cycles, then DONE.
    task automatic expectDone(input string tag, input logic expPass, input logic [3:0] expFail);
        repeat (NREGS - 1) stepCycle();
        checkOutput({tag, "_doneEarly"}, 64'(done), 64'd0);
        stepCycle();
        checkOutput({tag, "_done"},    64'(done),     64'd1);
        checkOutput({tag, "_pass"},    64'(pass),     64'(expPass));
        checkOutput({tag, "_failIdx"}, 64'(fail_idx), 64'(expFail));
    endtask

    task automatic haltAndCheck(input string tag, input logic expPass, input logic [3:0] expFail);
        halt = 1'b1;
        stepCycle();
        halt = 1'b0;
        expectDone(tag, expPass, expFail);
    endtask

    task automatic drainQueue(input string tag);
        for (int i = 0; i < 30 && expQ.size() != 0; i++) stepCycle();
        stepCycle();
        checkOutput({tag, "_drained"}, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        int popStart;

        // Reset state
        applyReset();
        checkOutput("rst_done",        64'(done),         64'd0);
        checkOutput("rst_pass",        64'(pass),         64'd0);
        checkOutput("rst_failIdx",     64'(fail_idx),     64'hF);
        checkOutput("rst_traceValid",  64'(trace_valid),  64'd0);
        checkOutput("rst_traceIdx",    64'(trace_idx),    64'd0);
        checkOutput("rst_traceData",   64'(trace_data),   64'd0);
        checkOutput("rst_traceCycle",  64'(trace_cycle),  64'd0);
        checkOutput("rst_overflow",    64'(overflow),     64'd0);
        checkOutput("rst_timedOut",    64'(timed_out),    64'd0);
        checkOutput("rst_commitCount", 64'(commit_count), 64'd0);

        // Basic pass
        loadExpected(4'd0, 32'd9);
        loadExpected(4'd1, 32'd15);
        loadExpected(4'd2, 32'd2);
        loadExpected(4'd3, 32'd30);
        loadExpected(4'd15, 32'd77);
        runStart();
        applyStimulus(1'b1, 4'd0, 32'd9,  1'b1);
        applyStimulus(1'b1, 4'd1, 32'd15, 1'b1);
        applyStimulus(1'b1, 4'd2, 32'd2,  1'b1);
        applyStimulus(1'b1, 4'd3, 32'd30, 1'b1);
        haltAndCheck("basic", 1'b1, 4'hF);
        checkOutput("basic_commitCount", 64'(commit_count), 64'd4);
        checkOutput("basic_timedOut",    64'(timed_out),    64'd0);
        drainQueue("basic");

        // Mismatch: R3 and R1 both wrong, lowest index is reported
        applyReset();
        loadExpected(4'd0, 32'd9);
        loadExpected(4'd1, 32'd15);
        loadExpected(4'd2, 32'd2);
        loadExpected(4'd3, 32'd30);
        runStart();
        applyStimulus(1'b1, 4'd0, 32'd9,  1'b1);
        applyStimulus(1'b1, 4'd2, 32'd2,  1'b1);
        applyStimulus(1'b1, 4'd3, 32'd29, 1'b1);
        applyStimulus(1'b1, 4'd1, 32'd14, 1'b1);
        haltAndCheck("mismatch", 1'b0, 4'd1);
        drainQueue("mismatch");

        // Last write wins, PC writes ignored, commit together with halt
        applyReset();
        loadExpected(4'd2, 32'd2);
        popStart = popCount;
        runStart();
        applyStimulus(1'b1, 4'd2,  32'd5,   1'b1);
        applyStimulus(1'b0, 4'd4,  32'd99,  1'b0);
        applyStimulus(1'b1, 4'd15, 32'd123, 1'b0);
        RegWriteW = 1'b1;
        WA3W      = 4'd2;
        ResultW   = 32'd2;
        begin
            traceT e;
            e.idx  = 4'd2;
            e.data = 32'd2;
            e.cyc  = CYC_W'(runCycle);
            expQ.push_back(e);
        end
        halt = 1'b1;
        stepCycle();
        halt      = 1'b0;
        RegWriteW = 1'b0;
        expectDone("lastWrite", 1'b1, 4'hF);
        checkOutput("lastWrite_commitCount", 64'(commit_count), 64'd2);
        drainQueue("lastWrite");
        checkOutput("lastWrite_pops", 64'(popCount - popStart), 64'd2);

        // FIFO overflow, then in-order drain
        applyReset();
        trace_ready = 1'b0;
        popStart    = popCount;
        runStart();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'(i), 32'h100 + 32'(i), (i < FIFO_DEPTH));
        end
        checkOutput("ovf_overflow",    64'(overflow),     64'd1);
        checkOutput("ovf_commitCount", 64'(commit_count), 64'd10);
        checkOutput("ovf_traceValid",  64'(trace_valid),  64'd1);
        checkOutput("ovf_headCycle",   64'(trace_cycle),  64'd0);
        trace_ready = 1'b1;
        drainQueue("ovf");
        checkOutput("ovf_pops",       64'(popCount - popStart), 64'd8);
        checkOutput("ovf_emptyValid", 64'(trace_valid),         64'd0);
        haltAndCheck("ovf", 1'b1, 4'hF);
        checkOutput("ovf_stickyOverflow", 64'(overflow), 64'd1);

        // Async reset from DONE, between edges
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arstDone_done",     64'(done),     64'd0);
        checkOutput("arstDone_pass",     64'(pass),     64'd0);
        checkOutput("arstDone_overflow", 64'(overflow), 64'd0);
        checkOutput("arstDone_failIdx",  64'(fail_idx), 64'hF);
        applyReset();

        // Timeout with all checked registers matching
        loadExpected(4'd5, 32'd0);
        runStart();
        repeat (TIMEOUT - 1) stepCycle();
        checkOutput("timeout_beforeLimit", 64'(timed_out), 64'd0);
        stepCycle();
        checkOutput("timeout_flag", 64'(timed_out), 64'd1);
        expectDone("timeout", 1'b0, 4'hF);

        // Async reset mid-RUN; run_en held during reset has no effect
        applyReset();
        trace_ready = 1'b0;
        runStart();
        applyStimulus(1'b1, 4'd1, 32'd11, 1'b0);
        applyStimulus(1'b1, 4'd2, 32'd22, 1'b0);
        applyStimulus(1'b1, 4'd3, 32'd33, 1'b0);
        checkOutput("arstRun_validBefore", 64'(trace_valid),  64'd1);
        checkOutput("arstRun_countBefore", 64'(commit_count), 64'd3);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arstRun_traceValid",  64'(trace_valid),  64'd0);
        checkOutput("arstRun_commitCount", 64'(commit_count), 64'd0);
        checkOutput("arstRun_done",        64'(done),         64'd0);
        run_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_en = 1'b0;
        reset  = 1'b1;
        applyStimulus(1'b1, 4'd2, 32'd77, 1'b0);
        stepCycle();
        checkOutput("arstRun_idleCount", 64'(commit_count), 64'd0);
        checkOutput("arstRun_idleValid", 64'(trace_valid),  64'd0);
        checkOutput("arstRun_idleDone",  64'(done),         64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
